// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, packet-locked arbiter sharing one UART TX core
// Grant is held for a whole packet; a watchdog revokes it if the owner stalls mid-packet.
module uart_tx_arbiter #(
    parameter int          NUM_REQ = 2,
    parameter logic [31:0] TIMEOUT = 32'd1000000
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NUM_REQ-1:0]     REQ_VALID,
    input  logic [8*NUM_REQ-1:0]   REQ_DATA,
    input  logic [NUM_REQ-1:0]     REQ_LAST,
    output logic [NUM_REQ-1:0]     REQ_READY,
    output logic [NUM_REQ-1:0]     GRANT,
    output logic [7:0]             TX_DATA,
    output logic                   TX_START,
    input  logic                   TX_BUSY,
    output logic                   TIMEOUT_PULSE
);

    localparam int              OW       = $clog2(NUM_REQ);
    localparam logic [OW-1:0]   LAST_IDX = OW'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} state_t;

    state_t             state, state_d;
    logic [NUM_REQ-1:0] grant_d;
    logic [OW-1:0]      owner, owner_d;
    logic [OW-1:0]      last_owner, last_owner_d;
    logic [7:0]         tx_data_d;
    logic               last_flag, last_flag_d;
    logic [31:0]        stall_cnt, stall_d;
    logic               pulse_d;

    logic [OW-1:0]      winner;
    logic [OW-1:0]      cand;
    logic               found;
    logic [7:0]         owner_byte;
    logic               owner_valid;
    logic               owner_last;
    logic               accept;

    // Scan starts one past the previous owner and wraps, so the first hit is the fair winner.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = last_owner;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (cand == LAST_IDX) ? '0 : cand + OW'(1);
            if (!found && REQ_VALID[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        owner_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == OW'(i)) begin
                owner_byte = REQ_DATA[8*i +: 8];
            end
        end
    end

    assign owner_valid = REQ_VALID[owner];
    assign owner_last  = REQ_LAST[owner];
    assign REQ_READY   = (state == SEND && !TX_BUSY) ? GRANT : '0;
    assign TX_START    = (state == WAIT_ACK);
    assign accept      = |(REQ_VALID & REQ_READY);

    always_comb begin
        state_d      = state;
        grant_d      = GRANT;
        owner_d      = owner;
        last_owner_d = last_owner;
        tx_data_d    = TX_DATA;
        last_flag_d  = last_flag;
        stall_d      = stall_cnt;
        pulse_d      = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_d          = SEND;
                    owner_d          = winner;
                    grant_d          = '0;
                    grant_d[winner]  = 1'b1;
                    stall_d          = '0;
                end
            end
            SEND: begin
                // An accept in the same cycle as the timeout wins; the counter never fires then.
                if (accept) begin
                    tx_data_d   = owner_byte;
                    last_flag_d = owner_last;
                    stall_d     = '0;
                    state_d     = WAIT_ACK;
                end else if (!owner_valid && TIMEOUT != 32'd0) begin
                    if (stall_cnt >= TIMEOUT - 32'd1) begin
                        pulse_d      = 1'b1;
                        grant_d      = '0;
                        last_owner_d = owner;
                        stall_d      = TIMEOUT;
                        state_d      = IDLE;
                    end else begin
                        stall_d = stall_cnt + 32'd1;
                    end
                end
            end
            WAIT_ACK: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!TX_BUSY) begin
                    if (last_flag) begin
                        grant_d      = '0;
                        last_owner_d = owner;
                        state_d      = IDLE;
                    end else begin
                        stall_d = '0;
                        state_d = SEND;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            GRANT         <= '0;
            owner         <= '0;
            last_owner    <= LAST_IDX;
            TX_DATA       <= 8'h00;
            last_flag     <= 1'b0;
            stall_cnt     <= '0;
            TIMEOUT_PULSE <= 1'b0;
        end else begin
            state         <= state_d;
            GRANT         <= grant_d;
            owner         <= owner_d;
            last_owner    <= last_owner_d;
            TX_DATA       <= tx_data_d;
            last_flag     <= last_flag_d;
            stall_cnt     <= stall_d;
            TIMEOUT_PULSE <= pulse_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int BUSY_CYC = 10;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [1:0]  REQ_VALID = '0;
    logic [15:0] REQ_DATA = '0;
    logic [1:0]  REQ_LAST = '0;
    logic [1:0]  REQ_READY;
    logic [1:0]  GRANT;
    logic [7:0]  TX_DATA;
    logic        TX_START;
    logic        TX_BUSY;
    logic        TIMEOUT_PULSE;

    logic        use_model = 1'b0;
    logic        tbl_busy  = 1'b0;
    int          busy_cnt  = 0;
    int          checks    = 0;
    int          errors    = 0;
    bit          logging   = 1'b0;
    logic [9:0]  log_q[$];

    uart_tx_arbiter #(.NUM_REQ(2), .TIMEOUT(32'd50)) dut (
        .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA),
        .REQ_LAST(REQ_LAST), .REQ_READY(REQ_READY), .GRANT(GRANT),
        .TX_DATA(TX_DATA), .TX_START(TX_START), .TX_BUSY(TX_BUSY),
        .TIMEOUT_PULSE(TIMEOUT_PULSE)
    );

    always #5 CLK = ~CLK;

    // UART TX core model: busy for BUSY_CYC cycles starting the cycle after TX_START.
    always @(posedge CLK) begin
        if (TX_START) busy_cnt <= BUSY_CYC;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign TX_BUSY = use_model ? (busy_cnt != 0) : tbl_busy;

    always @(negedge CLK) begin
        if (logging && TX_START) log_q.push_back({GRANT, TX_DATA});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1; REQ_VALID = '0; REQ_LAST = '0; REQ_DATA = '0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (BUSY_CYC + 2) @(negedge CLK);
    endtask

    // Waits for REQ_READY[idx]; returns at the negedge after the accepting edge.
    task automatic wait_accept(input int idx, input string name);
        bit seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            #1;
            if (REQ_READY[idx] && REQ_VALID[idx]) seen = 1'b1;
            @(negedge CLK);
        end
        check(name, 32'(seen), 32'd1);
    endtask

    typedef struct packed {
        logic [1:0] valid;
        logic [1:0] last;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       busy;
        logic [1:0] ready;
        logic [1:0] grant;
        logic       start;
        logic [7:0] txd;
    } vec_t;

    vec_t tbl[18];

    initial begin : main
        int idx[2];
        logic [1:0] acc;
        int viol;

        tbl[0]  = '{2'b01, 2'b00, 8'h41, 8'h00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00};
        tbl[1]  = '{2'b01, 2'b00, 8'h41, 8'h00, 1'b0, 2'b01, 2'b01, 1'b0, 8'h00};
        tbl[2]  = '{2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 2'b01, 1'b1, 8'h41};
        tbl[3]  = '{2'b01, 2'b01, 8'h42, 8'h00, 1'b1, 2'b00, 2'b01, 1'b0, 8'h41};
        tbl[4]  = '{2'b01, 2'b01, 8'h42, 8'h00, 1'b1, 2'b00, 2'b01, 1'b0, 8'h41};
        tbl[5]  = '{2'b01, 2'b01, 8'h42, 8'h00, 1'b0, 2'b00, 2'b01, 1'b0, 8'h41};
        tbl[6]  = '{2'b01, 2'b01, 8'h42, 8'h00, 1'b0, 2'b01, 2'b01, 1'b0, 8'h41};
        tbl[7]  = '{2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 2'b01, 1'b1, 8'h42};
        tbl[8]  = '{2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 2'b01, 1'b0, 8'h42};
        tbl[9]  = '{2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 2'b01, 1'b0, 8'h42};
        tbl[10] = '{2'b11, 2'b10, 8'h42, 8'h55, 1'b0, 2'b00, 2'b00, 1'b0, 8'h42};
        tbl[11] = '{2'b11, 2'b10, 8'h42, 8'h55, 1'b1, 2'b00, 2'b10, 1'b0, 8'h42};
        tbl[12] = '{2'b11, 2'b10, 8'h42, 8'h55, 1'b0, 2'b10, 2'b10, 1'b0, 8'h42};
        tbl[13] = '{2'b01, 2'b00, 8'h42, 8'h00, 1'b0, 2'b00, 2'b10, 1'b1, 8'h55};
        tbl[14] = '{2'b01, 2'b00, 8'h42, 8'h00, 1'b1, 2'b00, 2'b10, 1'b0, 8'h55};
        tbl[15] = '{2'b01, 2'b00, 8'h42, 8'h00, 1'b0, 2'b00, 2'b10, 1'b0, 8'h55};
        tbl[16] = '{2'b01, 2'b00, 8'h42, 8'h00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h55};
        tbl[17] = '{2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 2'b01, 2'b01, 1'b0, 8'h55};

        // Reset then idle
        repeat (3) @(negedge CLK);
        #1;
        check("reset_outputs", {GRANT, REQ_READY, TX_START, TX_DATA, TIMEOUT_PULSE}, 32'd0);
        RST = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK); #1;
            check($sformatf("idle_c%0d", c), {GRANT, REQ_READY, TX_START, TX_DATA, TIMEOUT_PULSE}, 32'd0);
        end

        // Table-driven single-requester and round-robin sequence
        for (int i = 0; i < 18; i++) begin
            @(negedge CLK);
            REQ_VALID = tbl[i].valid;
            REQ_LAST  = tbl[i].last;
            REQ_DATA  = {tbl[i].d1, tbl[i].d0};
            tbl_busy  = tbl[i].busy;
            #1;
            check($sformatf("vec%0d_ready", i), 32'(REQ_READY), 32'(tbl[i].ready));
            check($sformatf("vec%0d_grant", i), 32'(GRANT), 32'(tbl[i].grant));
            check($sformatf("vec%0d_start", i), 32'(TX_START), 32'(tbl[i].start));
            check($sformatf("vec%0d_txdata", i), 32'(TX_DATA), 32'(tbl[i].txd));
            check($sformatf("vec%0d_pulse", i), 32'(TIMEOUT_PULSE), 32'd0);
        end

        // Contention fairness with 3-byte packets
        use_model = 1'b1;
        tbl_busy  = 1'b0;
        do_reset();
        idx[0] = 0; idx[1] = 0;
        logging = 1'b1;
        for (int c = 0; c < 1000 && log_q.size() < 12; c++) begin
            @(negedge CLK);
            REQ_VALID = 2'b11;
            REQ_DATA  = {8'(8'h20 + idx[1]), 8'(8'h10 + idx[0])};
            REQ_LAST  = {idx[1] == 2, idx[0] == 2};
            #1;
            acc = REQ_VALID & REQ_READY;
            @(posedge CLK);
            for (int r = 0; r < 2; r++) if (acc[r]) idx[r] = (idx[r] == 2) ? 0 : idx[r] + 1;
        end
        logging = 1'b0;
        check("fair_count", 32'(log_q.size()), 32'd12);
        for (int k = 0; k < 12 && k < log_q.size(); k++) begin
            check($sformatf("fair_b%0d", k), 32'(log_q[k]),
                  ((k / 3) % 2 == 0) ? {22'd0, 2'b01, 8'(8'h10 + k % 3)}
                                     : {22'd0, 2'b10, 8'(8'h20 + k % 3)});
        end

        // Packet lock: req1 waits for req0's whole packet
        do_reset();
        viol = 0;
        REQ_VALID = 2'b01; REQ_DATA = 16'h0041; REQ_LAST = 2'b00;
        wait_accept(0, "lock_first_accept");
        REQ_VALID = 2'b11; REQ_DATA = 16'h7742; REQ_LAST = 2'b11;
        begin : second
            bit seen = 1'b0;
            for (int c = 0; c < 200 && !seen; c++) begin
                #1;
                if (REQ_READY[1]) viol++;
                if (REQ_READY[0]) seen = 1'b1;
                @(negedge CLK);
            end
            check("lock_second_accept", 32'(seen), 32'd1);
        end
        REQ_VALID = 2'b10;
        #1;
        check("lock_start", {TX_START, TX_DATA}, {23'd0, 1'b1, 8'h42});
        repeat (BUSY_CYC + 1) begin
            @(negedge CLK); #1;
            if (REQ_READY[1]) viol++;
        end
        check("lock_grant_t0", 32'(GRANT), 32'b01);
        @(negedge CLK); #1;
        check("lock_grant_t1", 32'(GRANT), 32'b00);
        @(negedge CLK); #1;
        check("lock_grant_t2", 32'(GRANT), 32'b10);
        check("lock_ready_t2", 32'(REQ_READY), 32'b10);
        check("lock_ready1_held", 32'(viol), 32'd0);

        // Watchdog: req0 stalls after one non-last byte, req1 waits
        do_reset();
        viol = 0;
        REQ_VALID = 2'b11; REQ_DATA = 16'h3330; REQ_LAST = 2'b00;
        wait_accept(0, "wd_accept");
        REQ_VALID = 2'b10;
        #1;
        check("wd_start", {TX_START, TX_DATA}, {23'd0, 1'b1, 8'h30});
        repeat (BUSY_CYC + 1) @(negedge CLK);
        for (int k = 1; k <= 50; k++) begin
            @(negedge CLK); #1;
            if (TIMEOUT_PULSE || GRANT != 2'b01) viol++;
        end
        check("wd_quiet_50", 32'(viol), 32'd0);
        @(negedge CLK); #1;
        check("wd_pulse", {TIMEOUT_PULSE, GRANT}, {29'd0, 1'b1, 2'b00});
        @(negedge CLK);
        REQ_VALID = 2'b00;
        #1;
        check("wd_next_grant", {TIMEOUT_PULSE, GRANT}, {29'd0, 1'b0, 2'b10});
        repeat (49) @(negedge CLK);
        REQ_VALID = 2'b10; REQ_DATA = 16'h5A00; REQ_LAST = 2'b10;
        #1;
        check("wd_tie_ready", 32'(REQ_READY), 32'b10);
        @(negedge CLK);
        REQ_VALID = 2'b00;
        #1;
        check("wd_tie_accept_wins", {TIMEOUT_PULSE, TX_START, TX_DATA}, {22'd0, 1'b0, 1'b1, 8'h5A});

        // Reset mid-packet
        do_reset();
        REQ_VALID = 2'b01; REQ_DATA = 16'h0041; REQ_LAST = 2'b00;
        wait_accept(0, "rst_accept");
        #1;
        check("rst_start", 32'(TX_START), 32'd1);
        @(negedge CLK);
        RST = 1'b1; REQ_VALID = 2'b11;
        @(negedge CLK); #1;
        check("rst_abort", {GRANT, REQ_READY, TX_START}, 32'd0);
        RST = 1'b0;
        @(negedge CLK); #1;
        check("rst_req0_first", 32'(GRANT), 32'b01);
        viol = 0;
        for (int c = 0; c < 6; c++) begin
            if (TX_START) viol++;
            @(negedge CLK); #1;
        end
        check("rst_no_spurious_start", 32'(viol), 32'd0);

        REQ_VALID = '0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
